// File: rtl/mmio_io_bank_if.sv
// Data-memory bus port of the I/O bank: word address, strobes, store data and
// registered read data, plus the combinational address-hit flag.
interface mmio_io_bank_if;
    logic [11:0] addr;
    logic        wEn;
    logic        rEn;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic        hit;

    modport master (output addr, wEn, rEn, dataIn, input dataOut, hit);
    modport slave  (input addr, wEn, rEn, dataIn, output dataOut, hit);
endinterface

// File: rtl/mmio_io_bank.sv
// Memory-mapped I/O bank: servo PWM channels with frame-aligned width updates
// and optional slew, synchronised buttons with sticky read-clear flags, tone reg.
module mmio_io_bank #(
    parameter int unsigned NUM_SERVO  = 3,
    parameter int unsigned NUM_BTN    = 6,
    parameter logic [11:0] BASE_ADDR  = 12'd32,
    parameter int unsigned PWM_PERIOD = 1000000,
    parameter int unsigned PULSE_MIN  = 25000,
    parameter int unsigned PULSE_STEP = 100,
    parameter int unsigned RAMP_DIV   = 0,
    parameter logic [9:0]  DUTY_RESET = 10'd512
) (
    input  logic                 clock,
    input  logic                 reset,
    mmio_io_bank_if.slave        bus,
    input  logic [NUM_BTN-1:0]   btn_in,
    output logic [NUM_SERVO-1:0] servo_out,
    output logic [3:0]           tone
);
    localparam int unsigned OFF_BTN  = 8;
    localparam int unsigned OFF_RAW  = 16;
    localparam int unsigned OFF_TONE = 17;
    localparam int unsigned OFF_BUSY = 18;

    logic [4:0] off;
    logic       hit_c;
    logic       wr_c;
    logic       rd_c;

    logic [NUM_BTN-1:0] sync1_q, sync2_q, prev_q, flag_q, flag_d;
    logic [NUM_BTN-1:0] edge_c, clr_c;

    logic [9:0]  target_q [NUM_SERVO];
    logic [9:0]  cur_q    [NUM_SERVO];
    logic [9:0]  cur_d    [NUM_SERVO];
    logic [31:0] width_q  [NUM_SERVO];
    logic [31:0] width_d  [NUM_SERVO];
    logic [NUM_SERVO-1:0] servo_q, servo_d, busy_c;

    logic [31:0] frame_q, ramp_q;
    logic        frame_start_c, ramp_tick_c;
    logic [3:0]  tone_q;
    logic [31:0] rdata_c, dataOut_q;
    logic        unused_data;

    // Block occupies the 32-word window starting at the aligned base address.
    assign off      = bus.addr[4:0];
    assign hit_c    = (bus.addr[11:5] == BASE_ADDR[11:5]);
    assign wr_c     = hit_c & bus.wEn;
    assign rd_c     = hit_c & bus.rEn & ~bus.wEn;
    assign bus.hit  = hit_c;
    assign bus.dataOut = dataOut_q;
    assign servo_out   = servo_q;
    assign tone        = tone_q;
    assign unused_data = ^bus.dataIn[31:10];

    assign frame_start_c = (frame_q == 32'd0);
    assign ramp_tick_c   = (RAMP_DIV != 0) && (ramp_q == 32'(RAMP_DIV - 1));

    // Button flags: a fresh edge outranks a clearing read in the same cycle.
    always_comb begin
        edge_c = sync2_q & ~prev_q;
        clr_c  = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (rd_c && (off == 5'(OFF_BTN + i))) clr_c[i] = 1'b1;
        end
        flag_d = (flag_q & ~clr_c) | edge_c;
    end

    // Servo slew, width latch at frame start (from pre-update current), PWM compare.
    always_comb begin
        for (int i = 0; i < NUM_SERVO; i++) begin
            cur_d[i] = cur_q[i];
            if (RAMP_DIV == 0) begin
                cur_d[i] = target_q[i];
            end else if (ramp_tick_c && (cur_q[i] < target_q[i])) begin
                cur_d[i] = cur_q[i] + 10'd1;
            end else if (ramp_tick_c && (cur_q[i] > target_q[i])) begin
                cur_d[i] = cur_q[i] - 10'd1;
            end
            width_d[i] = width_q[i];
            if (frame_start_c) begin
                width_d[i] = 32'(PULSE_MIN) + 32'(cur_q[i]) * 32'(PULSE_STEP);
            end
            servo_d[i] = (frame_q < width_d[i]);
            busy_c[i]  = (cur_q[i] != target_q[i]);
        end
    end

    // Read mux; unmapped offsets return zero.
    always_comb begin
        rdata_c = '0;
        for (int i = 0; i < NUM_SERVO; i++) begin
            if (off == 5'(i)) rdata_c = 32'(target_q[i]);
        end
        for (int i = 0; i < NUM_BTN; i++) begin
            if (off == 5'(OFF_BTN + i)) rdata_c = 32'(flag_q[i]);
        end
        if (off == 5'(OFF_RAW))  rdata_c = 32'(sync2_q);
        if (off == 5'(OFF_TONE)) rdata_c = 32'(tone_q);
        if (off == 5'(OFF_BUSY)) rdata_c = 32'(busy_c);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            flag_q    <= '0;
            frame_q   <= '0;
            ramp_q    <= '0;
            servo_q   <= '0;
            tone_q    <= '0;
            dataOut_q <= '0;
            for (int i = 0; i < NUM_SERVO; i++) begin
                target_q[i] <= DUTY_RESET;
                cur_q[i]    <= DUTY_RESET;
                width_q[i]  <= '0;
            end
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            flag_q  <= flag_d;
            frame_q <= (frame_q == 32'(PWM_PERIOD - 1)) ? 32'd0 : frame_q + 32'd1;
            ramp_q  <= ((RAMP_DIV == 0) || ramp_tick_c) ? 32'd0 : ramp_q + 32'd1;
            servo_q <= servo_d;
            for (int i = 0; i < NUM_SERVO; i++) begin
                cur_q[i]   <= cur_d[i];
                width_q[i] <= width_d[i];
                if (wr_c && (off == 5'(i))) target_q[i] <= bus.dataIn[9:0];
            end
            if (wr_c && (off == 5'(OFF_TONE))) tone_q <= bus.dataIn[3:0];
            if (rd_c) dataOut_q <= rdata_c;
        end
    end
endmodule

// File: tb/tb_mmio_io_bank.sv
// Directed bench: a jump-mode bank (u_dut) and a slew-mode bank (u_ramp) on a
// shared clock/reset, with hand-computed expectations at fixed cycle numbers.
module tb_mmio_io_bank;
    logic       clk;
    logic       rst;
    logic [5:0] btn0, btn1;
    logic [2:0] servo0, servo1;
    logic [3:0] tone0, tone1;
    int         cyc;
    int         hi0, hi1;
    int         checks;
    int         errors;

    mmio_io_bank_if bus0 ();
    mmio_io_bank_if bus1 ();

    mmio_io_bank #(
        .NUM_SERVO(3), .NUM_BTN(6), .BASE_ADDR(12'd32), .PWM_PERIOD(100),
        .PULSE_MIN(10), .PULSE_STEP(1), .RAMP_DIV(0), .DUTY_RESET(10'd20)
    ) u_dut (
        .clock(clk), .reset(rst), .bus(bus0), .btn_in(btn0),
        .servo_out(servo0), .tone(tone0)
    );

    mmio_io_bank #(
        .NUM_SERVO(3), .NUM_BTN(6), .BASE_ADDR(12'd32), .PWM_PERIOD(100),
        .PULSE_MIN(10), .PULSE_STEP(1), .RAMP_DIV(10), .DUTY_RESET(10'd20)
    ) u_ramp (
        .clock(clk), .reset(rst), .bus(bus1), .btn_in(btn1),
        .servo_out(servo1), .tone(tone1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge and accumulate pulse widths.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        hi0 += int'(servo0[0]);
        hi1 += int'(servo0[1]);
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic bus_wr(input int which, input logic [11:0] a, input logic [31:0] d);
        if (which == 0) begin
            bus0.addr = a; bus0.dataIn = d; bus0.wEn = 1'b1;
        end else begin
            bus1.addr = a; bus1.dataIn = d; bus1.wEn = 1'b1;
        end
        tick();
        bus0.wEn = 1'b0;
        bus1.wEn = 1'b0;
    endtask

    task automatic bus_rd(input int which, input logic [11:0] a, output logic [31:0] q);
        if (which == 0) begin
            bus0.addr = a; bus0.rEn = 1'b1;
        end else begin
            bus1.addr = a; bus1.rEn = 1'b1;
        end
        tick();
        q = (which == 0) ? bus0.dataOut : bus1.dataOut;
        bus0.rEn = 1'b0;
        bus1.rEn = 1'b0;
    endtask

    initial begin
        logic [31:0] q;
        checks = 0; errors = 0; cyc = 0; hi0 = 0; hi1 = 0;
        rst = 1'b1; btn0 = '0; btn1 = '0;
        bus0.addr = '0; bus0.wEn = 1'b0; bus0.rEn = 1'b0; bus0.dataIn = '0;
        bus1.addr = '0; bus1.wEn = 1'b0; bus1.rEn = 1'b0; bus1.dataIn = '0;
        repeat (3) tick();
        chk("reset_servo", 32'(servo0), 32'd0);
        chk("reset_dataout", bus0.dataOut, 32'd0);
        chk("reset_tone", 32'(tone0), 32'd0);

        // Idle PWM after reset: 30-cycle pulse starting on the first frame cycle.
        cyc = 0; hi0 = 0; hi1 = 0; rst = 1'b0;
        run_to(1);   chk("first_pulse_start", 32'(servo0[0]), 32'd1);
        run_to(30);  chk("pulse_last_high", 32'(servo0[0]), 32'd1);
        run_to(31);  chk("pulse_first_low", 32'(servo0[0]), 32'd0);
        run_to(100); chk("frame1_width", 32'(hi0), 32'd30);
        hi0 = 0;
        run_to(101); chk("frame2_start", 32'(servo0[0]), 32'd1);
        run_to(200); chk("frame2_width", 32'(hi0), 32'd30);
        run_to(250);
        chk("idle_dataout", bus0.dataOut, 32'd0);
        chk("idle_tone", 32'(tone0), 32'd0);

        // Mid-frame duty write takes effect only at the next frame start.
        run_to(300); hi0 = 0; hi1 = 0;
        run_to(340); bus_wr(0, 12'd33, 32'd50);
        run_to(345); bus_rd(0, 12'd33, q); chk("rd_target1", q, 32'd50);
        run_to(400); chk("inflight_frame_width", 32'(hi1), 32'd30);
        hi0 = 0; hi1 = 0;
        run_to(500);
        chk("new_frame_width", 32'(hi1), 32'd60);
        chk("other_channel_width", 32'(hi0), 32'd30);

        bus0.addr = 12'd31; #1; chk("hit_below_base", 32'(bus0.hit), 32'd0);
        bus0.addr = 12'd32; #1; chk("hit_base", 32'(bus0.hit), 32'd1);
        bus0.addr = 12'd63; #1; chk("hit_top", 32'(bus0.hit), 32'd1);
        bus0.addr = 12'd64; #1; chk("hit_above", 32'(bus0.hit), 32'd0);

        // Slew: ramp ticks land on cycles 610..650, so busy clears after 650.
        run_to(600); bus_wr(1, 12'd32, 32'd25);
        chk("ramp_bus_hit", 32'(bus1.hit), 32'd1);
        run_to(605); bus_rd(1, 12'd50, q); chk("ramp_busy_early", q, 32'd1);
        run_to(649); bus_rd(1, 12'd50, q); chk("ramp_busy_last", q, 32'd1);
        bus_rd(1, 12'd50, q); chk("ramp_busy_done", q, 32'd0);
        bus_rd(1, 12'd32, q); chk("ramp_target", q, 32'd25);

        // Button 2: flag sets on the third edge after the input rises.
        run_to(700); btn0[2] = 1'b1;
        run_to(702); bus_rd(0, 12'd42, q); chk("btn_flag_latency", q, 32'd0);
        bus_rd(0, 12'd48, q); chk("btn_raw_high", q, 32'h4);
        run_to(705); btn0[2] = 1'b0;
        run_to(710);
        bus_rd(0, 12'd42, q); chk("btn_flag_first_read", q, 32'd1);
        bus_rd(0, 12'd42, q); chk("btn_flag_cleared", q, 32'd0);
        bus_rd(0, 12'd48, q); chk("btn_raw_released", q, 32'd0);

        // Button 3: second edge coincides with a clearing read.
        run_to(720); btn0[3] = 1'b1;
        run_to(722); btn0[3] = 1'b0;
        run_to(730); btn0[3] = 1'b1;
        run_to(732);
        bus_rd(0, 12'd43, q); chk("btn_setwins_old", q, 32'd1);
        bus_rd(0, 12'd43, q); chk("btn_setwins_kept", q, 32'd1);
        bus_rd(0, 12'd43, q); chk("btn_setwins_clear", q, 32'd0);
        btn0[3] = 1'b0;

        // Unmapped offsets and simultaneous write/read.
        run_to(740); bus_wr(0, 12'd52, 32'hFFFF_FFFF);
        bus_rd(0, 12'd52, q); chk("unmapped_off20", q, 32'd0);
        bus_rd(0, 12'd37, q); chk("unmapped_off5", q, 32'd0);
        bus_rd(0, 12'd46, q); chk("unmapped_off14", q, 32'd0);
        bus0.addr = 12'd32; bus0.dataIn = 32'd7; bus0.wEn = 1'b1; bus0.rEn = 1'b1;
        tick();
        bus0.wEn = 1'b0; bus0.rEn = 1'b0;
        chk("wr_rd_dataout_held", bus0.dataOut, 32'd0);
        bus_rd(0, 12'd32, q); chk("wr_rd_write_done", q, 32'd7);

        // Tone, then reset in the middle of a pulse.
        run_to(790); btn0[0] = 1'b1;
        run_to(795); btn0[0] = 1'b0;
        run_to(800); bus_wr(0, 12'd49, 32'h0000_000A);
        chk("tone_written", 32'(tone0), 32'hA);
        bus_rd(0, 12'd49, q); chk("tone_readback", q, 32'hA);
        run_to(810); chk("pre_reset_high", 32'(servo0[0]), 32'd1);
        rst = 1'b1;
        tick();
        chk("reset_servo_low", 32'(servo0), 32'd0);
        chk("reset_tone_clear", 32'(tone0), 32'd0);
        chk("reset_dataout_clear", bus0.dataOut, 32'd0);
        chk("reset_ramp_servo_low", 32'(servo1), 32'd0);
        chk("reset_ramp_tone", 32'(tone1), 32'd0);
        tick();
        rst = 1'b0; hi0 = 0; hi1 = 0;
        run_to(813); chk("restart_pulse", 32'(servo0[0]), 32'd1);
        run_to(815);
        bus_rd(0, 12'd40, q); chk("flag_after_reset", q, 32'd0);
        bus_rd(0, 12'd33, q); chk("target_after_reset", q, 32'd20);
        bus0.addr = 12'd31; #1; chk("hit_base_minus1", 32'(bus0.hit), 32'd0);
        run_to(842); chk("restart_last_high", 32'(servo0[0]), 32'd1);
        run_to(843); chk("restart_first_low", 32'(servo0[0]), 32'd0);
        run_to(912);
        chk("restart_width_ch0", 32'(hi0), 32'd30);
        chk("restart_width_ch1", 32'(hi1), 32'd30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmio_io_bank.md
# mmio_io_bank

Parametrised memory-mapped I/O bank on the processor data-memory bus. It provides NUM_SERVO servo PWM channels with glitch-free period-aligned updates and optional slew limiting, plus NUM_BTN button inputs with synchronisers, sticky rising-edge flags cleared on read, and a tone register. The wrapper routes `dataOut` to the CPU whenever `hit` is high, and to RAM data otherwise.

## Interface
- NUM_SERVO, 3: servo channels, 1..8
- NUM_BTN, 6: button inputs, 1..8
- BASE_ADDR, 12'd32: word address of offset 0; must be 32-aligned
- PWM_PERIOD, 1000000: clock cycles per PWM frame (20 ms at 50 MHz)
- PULSE_MIN, 25000: high cycles at duty 0
- PULSE_STEP, 100: extra high cycles per duty count
- RAMP_DIV, 0: cycles per 1-count slew step; 0 = no slew (jump)
- DUTY_RESET, 10'd512: reset target/current duty
- clock  in  1  system clock (50 MHz domain)
- reset  in  1  synchronous, active-high
- addr  in  12  word address (memAddr[11:0])
- wEn  in  1  store strobe
- rEn  in  1  load strobe (decoded load in MEM stage)
- dataIn  in  32  store data
- dataOut  out  32  registered read data
- hit  out  1  combinational: addr within BASE_ADDR..BASE_ADDR+31
- btn_in  in  NUM_BTN  asynchronous button levels
- servo_out  out  NUM_SERVO  PWM outputs
- tone  out  4  tone select to audio block

## Operation
- Offset map (off = addr - BASE_ADDR): 0..NUM_SERVO-1 servo target duty (RW, bits [9:0]); 8..8+NUM_BTN-1 button event flag (R, bit 0, read-clear); 16 raw synchronised levels (R, bits [NUM_BTN-1:0]); 17 tone (RW, bits [3:0]); 18 servo busy mask (R, bit i = current≠target). Unmapped offsets: read 0, writes ignored.
- Buttons: 2-flop synchroniser, then a rising-edge detector on the synchronised level. An edge sets flag[i]. A read of offset 8+i with rEn clears flag[i] on the same edge that captures dataOut. If an edge and a clear land in the same cycle, set wins.
- Servo targets: a write stores dataIn[9:0] into target[i].
  - RAMP_DIV=0: current[i] := target[i] the next cycle.
  - Otherwise: a shared RAMP_DIV counter pulses once per RAMP_DIV cycles. Each pulse moves current[i] by ±1 toward target[i], and never overshoots.
- PWM: one shared frame counter runs 0..PWM_PERIOD-1 and wraps.
  - At count 0, each channel latches width[i] = PULSE_MIN + current[i]*PULSE_STEP (32-bit arithmetic).
  - servo_out[i] = (count < width[i]).
  - Widths ≥ PWM_PERIOD give a constant high.
  - A duty change mid-frame never alters the frame in progress.
- Tone: a write to offset 17 stores dataIn[3:0]; tone reflects the register.
- If wEn and rEn are both high, the write executes and rEn is ignored.

## Timing
- Reset values:
  - servo_out 0, dataOut 0, tone 0
  - flags 0, synchronisers 0, edge-detector history 0
  - target = current = DUTY_RESET
  - frame counter 0, ramp counter 0
- Widths are latched on the first count-0 cycle after reset deasserts, so the first pulse starts that cycle.
- Read latency is 1 cycle: addr/rEn sampled at edge N, dataOut valid after edge N, held until the next rEn hit. This matches RAM latency.
- Write latency is 1 cycle to the register. A servo change reaches the pin at the next frame start after current updates.
- Button to flag: 3 cycles (2 sync + edge register).
- Reset mid-frame forces servo_out low on the next edge and restarts the frame at count 0.
- Ramp counter wrap, frame counter wrap and a width latch can coincide; each is independent, and the latch uses the pre-update current.

## Test plan
- Reset, then PWM_PERIOD=100, PULSE_MIN=10, PULSE_STEP=1, DUTY_RESET=20, then idle 250 cycles -> servo_out[0] high exactly 30 cycles per 100, starting at count 0; dataOut=0; tone=0.
- Write 50 to offset 1 at frame count 40 -> frame in progress keeps a 30-cycle pulse; the next frame pulse is 60 cycles; reading offset 1 returns 50 one cycle after rEn.
- RAMP_DIV=10, target 0→25 written at current=20 -> current steps +1 every 10 cycles and reaches 25 after 50 cycles; offset 18 bit 0 reads 1 during the ramp and 0 after.
- Pulse btn_in[2] high for 5 cycles, wait 5, read offset 10 twice -> first read 1, second read 0; offset 16 reads 0 after release.
- Button edge arrives in the same cycle as a clearing read of that flag -> read returns the old value and the flag stays 1.
- Write 0xA to offset 17, then assert reset mid-frame -> tone=0xA before reset; after reset tone=0, servo_out low the next cycle, flags 0, and the frame restarts with a DUTY_RESET-width pulse; an access at BASE_ADDR-1 leaves hit=0.
